// File: rtl/im_loader.sv
// Boot-time instruction loader: assembles big-endian words from a byte stream,
// writes them to instruction memory from address 0, and releases the CPU on a good checksum.
module im_loader (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_VALID,
  input  logic [7:0]  RX_DATA,
  output logic        RX_READY,
  output logic        IM_WE,
  output logic [15:0] IM_ADDR,
  output logic [31:0] IM_DATA,
  output logic        CPU_RST_F,
  output logic        DONE,
  output logic        ERR,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [23:0] shift_q, shift_d;
  logic        im_we_q, im_we_d;
  logic [15:0] im_addr_q, im_addr_d;
  logic [31:0] im_data_q, im_data_d;
  logic        rx_ready_q, rx_ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_rst_f_q, cpu_rst_f_d;
  logic        accept;

  // Handshake: a byte transfers on a rising edge where RX_VALID && RX_READY.
  // RX_READY is a registered decode of the state and never depends on RX_VALID,
  // so the source may hold or drop RX_VALID freely; RX_DATA is ignored otherwise.
  always_comb begin
    accept     = RX_VALID && rx_ready_q;
    state_d    = state_q;
    count_d    = count_q;
    xor_d      = xor_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_data_d  = im_data_q;

    if (accept) begin
      // The checksum byte itself is excluded from the running XOR.
      if (state_q != S_CHK) begin
        xor_d = xor_q ^ RX_DATA;
      end
      case (state_q)
        S_CNT_HI: begin
          count_d[15:8] = RX_DATA;
          state_d       = S_CNT_LO;
        end
        S_CNT_LO: begin
          count_d[7:0] = RX_DATA;
          state_d      = ({count_q[15:8], RX_DATA} != 16'd0) ? S_DATA : S_CHK;
        end
        S_DATA: begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_addr_d  = word_idx_q;
            im_data_d  = {shift_q, RX_DATA};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) begin
              state_d = S_CHK;
            end
          end else begin
            shift_d = {shift_q[15:0], RX_DATA};
          end
        end
        S_CHK: begin
          state_d = (RX_DATA == xor_q) ? S_DONE : S_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    rx_ready_d  = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                  (state_d == S_DATA)   || (state_d == S_CHK);
    done_d      = (state_d == S_DONE);
    cpu_rst_f_d = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_CNT_HI;
      count_q     <= 16'd0;
      xor_q       <= 8'd0;
      byte_idx_q  <= 2'd0;
      word_idx_q  <= 16'd0;
      shift_q     <= 24'd0;
      im_we_q     <= 1'b0;
      im_addr_q   <= 16'd0;
      im_data_q   <= 32'd0;
      rx_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_f_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      xor_q       <= xor_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      shift_q     <= shift_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_data_q   <= im_data_d;
      rx_ready_q  <= rx_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_f_q <= cpu_rst_f_d;
    end
  end

  assign RX_READY  = rx_ready_q;
  assign IM_WE     = im_we_q;
  assign IM_ADDR   = im_addr_q;
  assign IM_DATA   = im_data_q;
  assign CPU_RST_F = cpu_rst_f_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

  // A write needs four accepted bytes, so strobes can never be adjacent.
  a_we_pulse: assert property (@(posedge CLK) disable iff (RST) IM_WE |=> !IM_WE);
  a_done_err: assert property (@(posedge CLK) disable iff (RST) !(DONE && ERR));
  a_cpu_rel:  assert property (@(posedge CLK) disable iff (RST) CPU_RST_F == DONE);

endmodule
